frame_tx_scheduler: RTL and testbench

- Shares one frame_assembly instance between N_REQ requesters.
- Arbitrates pending transmit requests round-robin and latches the winner's header and payload fields.
- Pulses the assembler start, waits for its done, then acknowledges the winner.
- Watchdog on done: a stalled assembler cannot lock the scheduler.

---
 rtl/frame_tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_frame_tx_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: shares one frame assembler between N_REQ requesters.
// Round-robin arbitration, field latching, start/done handshake and a
// watchdog that aborts a frame whose done never arrives.
module frame_tx_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [16*N_REQ-1:0]  i_dst,
  input  logic [16*N_REQ-1:0]  i_src,
  input  logic [16*N_REQ-1:0]  i_size,
  input  logic [N_REQ-1:0]     i_dir,
  input  logic [7*N_REQ-1:0]   i_type,
  input  logic [336*N_REQ-1:0] i_payload,
  output logic [15:0]          o_dst,
  output logic [15:0]          o_src,
  output logic [15:0]          o_size,
  output logic                 o_dir,
  output logic [6:0]           o_type,
  output logic [335:0]         o_payload,
  output logic                 o_start,
  input  logic                 i_fa_done,
  output logic [N_REQ-1:0]     o_grant,
  output logic [N_REQ-1:0]     o_ack,
  output logic [N_REQ-1:0]     o_err,
  output logic                 o_busy,
  output logic [15:0]          o_frame_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    winner_q, winner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      dst_q, dst_d, src_q, src_d, size_q, size_d;
  logic             dir_q, dir_d;
  logic [6:0]       type_q, type_d;
  logic [335:0]     payload_q, payload_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!win_found && i_req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT -> GAP -> IDLE.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    ack_d       = '0;
    err_d       = '0;
    wd_d        = wd_q;
    frame_cnt_d = frame_cnt_q;
    dst_d       = dst_q;
    src_d       = src_q;
    size_d      = size_q;
    dir_d       = dir_q;
    type_d      = type_q;
    payload_d   = payload_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d           = S_ISSUE;
          ptr_d             = win_idx;
          winner_d          = win_idx;
          grant_d           = '0;
          grant_d[win_idx]  = 1'b1;
          dst_d             = i_dst[int'(win_idx)*16 +: 16];
          src_d             = i_src[int'(win_idx)*16 +: 16];
          size_d            = i_size[int'(win_idx)*16 +: 16];
          dir_d             = i_dir[win_idx];
          type_d            = i_type[int'(win_idx)*7 +: 7];
          payload_d         = i_payload[int'(win_idx)*336 +: 336];
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // Done takes priority over a watchdog expiry in the same cycle.
        if (i_fa_done) begin
          ack_d[winner_q] = 1'b1;
          frame_cnt_d     = frame_cnt_q + 16'd1;
          grant_d         = '0;
          state_d         = S_GAP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_d[winner_q] = 1'b1;
          grant_d         = '0;
          state_d         = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the latched fields are reset too, so every output is 0 during reset.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(N_REQ - 1);
      winner_q    <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      wd_q        <= '0;
      frame_cnt_q <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      size_q      <= '0;
      dir_q       <= 1'b0;
      type_q      <= '0;
      payload_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      frame_cnt_q <= frame_cnt_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      size_q      <= size_d;
      dir_q       <= dir_d;
      type_q      <= type_d;
      payload_q   <= payload_d;
    end
  end

  assign o_start     = (state_q == S_ISSUE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_grant     = grant_q;
  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_dst       = dst_q;
  assign o_src       = src_q;
  assign o_size      = size_q;
  assign o_dir       = dir_q;
  assign o_type      = type_q;
  assign o_payload   = payload_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed bench for frame_tx_scheduler with N_REQ=4, TIMEOUT=64.
module tb_frame_tx_scheduler;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     i_req = '0;
  logic [16*N_REQ-1:0]  i_dst, i_src, i_size;
  logic [N_REQ-1:0]     i_dir;
  logic [7*N_REQ-1:0]   i_type;
  logic [336*N_REQ-1:0] i_payload;
  logic                 i_fa_done = 1'b0;
  logic [15:0]          o_dst, o_src, o_size, o_frame_cnt;
  logic                 o_dir, o_start, o_busy;
  logic [6:0]           o_type;
  logic [335:0]         o_payload;
  logic [N_REQ-1:0]     o_grant, o_ack, o_err;

  int n_tests = 0;
  int n_fail  = 0;

  frame_tx_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req),
    .i_dst(i_dst), .i_src(i_src), .i_size(i_size), .i_dir(i_dir),
    .i_type(i_type), .i_payload(i_payload),
    .o_dst(o_dst), .o_src(o_src), .o_size(o_size), .o_dir(o_dir),
    .o_type(o_type), .o_payload(o_payload), .o_start(o_start),
    .i_fa_done(i_fa_done), .o_grant(o_grant), .o_ack(o_ack), .o_err(o_err),
    .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  // Per-requester field values used both to drive inputs and as expectations.
  function automatic logic [15:0] dst_of(int k);
    return (k == 0) ? 16'h1234 : 16'(16'hA000 + k);
  endfunction
  function automatic logic [15:0] src_of(int k);
    return 16'(16'h5000 + 16 * k);
  endfunction
  function automatic logic [15:0] size_of(int k);
    return 16'(100 + k);
  endfunction
  function automatic logic [6:0] type_of(int k);
    return 7'(7'h10 + k);
  endfunction
  function automatic logic [335:0] pay_of(int k);
    logic [7:0] b;
    b = 8'(8'hA0 + k);
    return {42{b}};
  endfunction
  function automatic int idx_of(logic [N_REQ-1:0] g);
    for (int i = 0; i < N_REQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [335:0] got, input logic [335:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One frame from an IDLE negedge with i_req already set; ends at the IDLE negedge after GAP.
  // done_k = WAIT cycle (1-based) in which done is driven, 0 = never.
  task automatic frame(input string tag, input logic [N_REQ-1:0] g, input int done_k,
                       input bit exp_ack, input logic [15:0] exp_cnt,
                       input int drop_k, input bit poke);
    int k;
    int w;
    w = idx_of(g);
    tick();
    check({tag, " grant"}, o_grant, g);
    check({tag, " start"}, o_start, 1'b1);
    check({tag, " busy"},  o_busy, 1'b1);
    check({tag, " dst"},   o_dst, dst_of(w));
    check({tag, " src"},   o_src, src_of(w));
    check({tag, " size"},  o_size, size_of(w));
    check({tag, " dir"},   o_dir, w[0]);
    check({tag, " type"},  o_type, type_of(w));
    check({tag, " pay"},   o_payload, pay_of(w));
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) begin
        check({tag, " start off"}, o_start, 1'b0);
        check({tag, " grant wait"}, o_grant, g);
      end
      if (k == drop_k) i_req = '0;
      if (poke && k == 2) i_dst[15:0] = ~dst_of(0);
      if (poke && k == 3) check({tag, " dst hold"}, o_dst, dst_of(0));
      if (k == TIMEOUT) begin
        check({tag, " err early"}, o_err, '0);
        check({tag, " grant last"}, o_grant, g);
      end
      if (k == done_k) i_fa_done = 1'b1;
    end while (!(k == done_k || k == TIMEOUT));
    tick();
    i_fa_done = 1'b0;
    if (poke) i_dst[15:0] = dst_of(0);
    check({tag, " ack"},  o_ack, exp_ack ? g : '0);
    check({tag, " err"},  o_err, exp_ack ? '0 : g);
    check({tag, " gap grant"}, o_grant, '0);
    check({tag, " gap busy"},  o_busy, 1'b1);
    check({tag, " cnt"},  o_frame_cnt, exp_cnt);
    tick();
    check({tag, " ack pulse"}, o_ack, '0);
    check({tag, " err pulse"}, o_err, '0);
    check({tag, " idle busy"}, o_busy, 1'b0);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, " rst grant"}, o_grant, '0);
    check({tag, " rst ack"},   o_ack, '0);
    check({tag, " rst err"},   o_err, '0);
    check({tag, " rst start"}, o_start, 1'b0);
    check({tag, " rst busy"},  o_busy, 1'b0);
    check({tag, " rst cnt"},   o_frame_cnt, 16'h0);
    check({tag, " rst dst"},   o_dst, 16'h0);
    check({tag, " rst pay"},   o_payload, '0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int k = 0; k < N_REQ; k++) begin
      i_dst[16*k +: 16]      = dst_of(k);
      i_src[16*k +: 16]      = src_of(k);
      i_size[16*k +: 16]     = size_of(k);
      i_dir[k]               = k[0];
      i_type[7*k +: 7]       = type_of(k);
      i_payload[336*k +: 336] = pay_of(k);
    end

    reset_dut("init");

    // Single request from requester 0.
    i_req = 4'b0001;
    frame("single", 4'b0001, 52, 1'b1, 16'd1, 0, 1'b0);
    i_req = '0;

    // Done while idle is ignored.
    i_fa_done = 1'b1;
    tick();
    i_fa_done = 1'b0;
    tick();
    check("idle done cnt",  o_frame_cnt, 16'd1);
    check("idle done busy", o_busy, 1'b0);
    check("idle done ack",  o_ack, '0);

    // Fairness from a fresh pointer: 0,1,2,3,0.
    reset_dut("fair");
    i_req = 4'b1111;
    frame("rr0", 4'b0001, 3, 1'b1, 16'd1, 0, 1'b0);
    frame("rr1", 4'b0010, 5, 1'b1, 16'd2, 0, 1'b0);
    frame("rr2", 4'b0100, 1, 1'b1, 16'd3, 0, 1'b0);
    frame("rr3", 4'b1000, 7, 1'b1, 16'd4, 0, 1'b0);
    frame("rr4", 4'b0001, 2, 1'b1, 16'd5, 0, 1'b0);

    // Timeout, then normal service with a request dropped mid-frame.
    i_req = 4'b0100;
    frame("tmo", 4'b0100, 0, 1'b0, 16'd5, 0, 1'b0);
    i_req = 4'b1000;
    frame("after", 4'b1000, 10, 1'b1, 16'd6, 2, 1'b0);

    // Done on the last watchdog cycle: ack wins.
    i_req = 4'b0001;
    frame("coll", 4'b0001, TIMEOUT, 1'b1, 16'd7, 0, 1'b0);

    // Field stability while the source changes during WAIT.
    frame("stab", 4'b0001, 20, 1'b1, 16'd8, 0, 1'b1);

    // Reset in the middle of WAIT.
    tick();
    check("pre mid busy", o_busy, 1'b1);
    tick();
    tick();
    tick();
    i_req = '0;
    reset_dut("mid");
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post rst ack", o_ack, '0);
    end
    i_req = 4'b0010;
    frame("post", 4'b0010, 8, 1'b1, 16'd1, 0, 1'b0);
    i_req = '0;

    // Counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    check("preload cnt", o_frame_cnt, 16'hFFFF);
    i_req = 4'b0100;
    frame("wrap", 4'b0100, 5, 1'b1, 16'h0000, 0, 1'b0);
    i_req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
